// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM state encoding and port indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Round-robin pointer values: the port that wins a simultaneous request.
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port favoured on a tie.
// Latency: grants are combinational from req/en/pointer; the pointer moves at the edge after a grant.
// Backpressure: a non-granted requester simply sees gnt=0 and must hold its request.
// Ports: clk, rst (sync active-low); en gates all grants; req0/req1 in; gnt0/gnt1 out (one-hot or zero).
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (en) begin
            if (req0 && (!req1 || ptr_q == P0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        // Hand priority to the loser; an idle cycle leaves the pointer alone.
        if (gnt0) begin
            ptr_d = P1;
        end else if (gnt1) begin
            ptr_d = P0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= P0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core p0, debug/DMA p1) round-robin arbiter in front of a single-port data memory.
// Latency: grant and memory drive are combinational; read data/rvalid are registered, one cycle after grant.
// Backpressure: one access per cycle; the losing port sees gnt=0 and must hold req/addr/we/wdata.
// Ports: clk, rst (sync active-low); pX_req/we/addr/wdata in, pX_gnt/rdata/rvalid/err out for X=0,1;
//        mem_A/mem_WD/mem_WE out, mem_RD in (combinational read); clr_start in, clr_busy out.
// Optional macro DMEM_ARB_CLEAR_EN adds a CLEAR state that zero-fills all DEPTH words; without it
// clr_start is ignored and clr_busy is tied low.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              p1_err,
    output logic [31:0]       mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD,
    input  logic              clr_start,
    output logic              clr_busy
);

    state_e state_q;
    state_e state_d;
    logic   arb_en;

    logic p0_oor;
    logic p1_oor;
    assign p0_oor = (p0_addr >= 32'(DEPTH));
    assign p1_oor = (p1_addr >= 32'(DEPTH));

    // ---------------------------------------------------------------- FSM
`ifdef DMEM_ARB_CLEAR_EN
    logic [31:0] clr_cnt_q;
    logic [31:0] clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        arb_en    = 1'b0;
        clr_busy  = 1'b0;
        case (state_q)
            ARB: begin
                // A clear request wins over any pending port request this cycle.
                arb_en = rst && !clr_start;
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_cnt_q == 32'(DEPTH - 1)) begin
                    state_d   = ARB;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 32'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ARB;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_busy         = 1'b0;

    always_comb begin
        state_d = ARB;
        arb_en  = rst && (state_q == ARB);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    // ---------------------------------------------------------- arbitration
    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (arb_en),
        .req0 (p0_req),
        .req1 (p1_req),
        .gnt0 (p0_gnt),
        .gnt1 (p1_gnt)
    );

    // ------------------------------------------------------ memory datapath
    always_comb begin
        mem_A  = '0;
        mem_WD = '0;
        mem_WE = 1'b0;
        p0_err = 1'b0;
        p1_err = 1'b0;
        if (p0_gnt) begin
            mem_A  = p0_addr;
            mem_WD = p0_wdata;
            mem_WE = p0_we && !p0_oor;
            p0_err = p0_oor;
        end else if (p1_gnt) begin
            mem_A  = p1_addr;
            mem_WD = p1_wdata;
            mem_WE = p1_we && !p1_oor;
            p1_err = p1_oor;
        end
`ifdef DMEM_ARB_CLEAR_EN
        if (state_q == CLEAR) begin
            mem_A  = clr_cnt_q;
            mem_WD = '0;
            mem_WE = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------- read registers
    logic              p0_rvalid_q, p0_rvalid_d;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q,  p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q,  p1_rdata_d;

    always_comb begin
        p0_rvalid_d = p0_gnt && !p0_we;
        p1_rvalid_d = p1_gnt && !p1_we;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        // Out-of-range reads still complete, returning zero.
        if (p0_rvalid_d) begin
            p0_rdata_d = p0_oor ? '0 : mem_RD;
        end
        if (p1_rvalid_d) begin
            p1_rdata_d = p1_oor ? '0 : mem_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory attached.
// Inputs change on the falling edge; outputs are sampled 1 time unit after either edge.
// Build with or without DMEM_ARB_CLEAR_EN; the clear-sweep section follows the macro.
module tb_dmem_arbiter;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [31:0]       p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic [31:0]       mem_A;
    logic [DATA_W-1:0] mem_WD, mem_RD;
    logic              mem_WE;
    logic              clr_start, clr_busy;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_WE && mem_A < 32'(DEPTH)) begin
            mem[mem_A[6:0]] <= mem_WD;
        end
    end
    assign mem_RD = (mem_A < 32'(DEPTH)) ? mem[mem_A[6:0]] : '0;

    dmem_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rdata  (p0_rdata),
        .p0_rvalid (p0_rvalid),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rdata  (p1_rdata),
        .p1_rvalid (p1_rvalid),
        .p1_err    (p1_err),
        .mem_A     (mem_A),
        .mem_WD    (mem_WD),
        .mem_WE    (mem_WE),
        .mem_RD    (mem_RD),
        .clr_start (clr_start),
        .clr_busy  (clr_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    endtask

    task automatic after_rise();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a pending p0 write: nothing may be granted or written.
        rst = 1'b0;
        clr_start = 1'b0;
        drv0(1'b1, 1'b1, 32'd3, 32'hFFFF_FFFF);
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        after_rise();
        chk("rst_p0_gnt",    p0_gnt,    0);
        chk("rst_p1_gnt",    p1_gnt,    0);
        chk("rst_mem_we",    mem_WE,    0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        chk("rst_p0_rdata",  p0_rdata,  0);
        chk("rst_p1_rdata",  p1_rdata,  0);
        chk("rst_p0_err",    p0_err,    0);
        chk("rst_clr_busy",  clr_busy,  0);

        // p0 write addr 5, then read it back.
        @(negedge clk);
        rst = 1'b1;
        drv0(1'b1, 1'b1, 32'd5, 32'hA5A5_A5A5);
        #1;
        chk("w5_p0_gnt", p0_gnt, 1);
        chk("w5_p1_gnt", p1_gnt, 0);
        chk("w5_mem_we", mem_WE, 1);
        chk("w5_mem_a",  mem_A,  32'd5);
        chk("w5_mem_wd", mem_WD, 32'hA5A5_A5A5);
        after_rise();
        chk("w5_rvalid", p0_rvalid, 0);
        chk("w5_mem",    mem[5],    32'hA5A5_A5A5);

        @(negedge clk);
        drv0(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        chk("r5_p0_gnt", p0_gnt, 1);
        chk("r5_mem_we", mem_WE, 0);
        after_rise();
        chk("r5_rvalid", p0_rvalid, 1);
        chk("r5_rdata",  p0_rdata,  32'hA5A5_A5A5);

        @(negedge clk);
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("idle_p0_gnt", p0_gnt, 0);
        chk("idle_mem_a",  mem_A,  0);
        chk("idle_mem_wd", mem_WD, 0);
        after_rise();
        chk("idle_rvalid",     p0_rvalid, 0);
        chk("idle_rdata_hold", p0_rdata,  32'hA5A5_A5A5);

        // Fresh reset so the round-robin sequence starts from p0.
        @(negedge clk);
        rst = 1'b0;
        after_rise();
        chk("rst2_p0_rdata", p0_rdata, 0);

        @(negedge clk);
        rst = 1'b1;
        drv0(1'b1, 1'b0, 32'd5, 32'd0);
        drv1(1'b1, 1'b1, 32'd10, 32'hCAFE_0001);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_p0_gnt", p0_gnt, 32'(k % 2 == 0));
            chk("rr_p1_gnt", p1_gnt, 32'(k % 2 == 1));
            after_rise();
            chk("rr_p0_rvalid", p0_rvalid, 32'(k % 2 == 0));
            chk("rr_p1_rvalid", p1_rvalid, 0);
            @(negedge clk);
        end

        // Back-to-back p1 reads.
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        drv1(1'b1, 1'b0, 32'd10, 32'd0);
        #1;
        chk("b2b1_p1_gnt", p1_gnt, 1);
        after_rise();
        chk("b2b1_rvalid", p1_rvalid, 1);
        chk("b2b1_rdata",  p1_rdata,  32'hCAFE_0001);
        @(negedge clk);
        drv1(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        chk("b2b2_p1_gnt", p1_gnt, 1);
        after_rise();
        chk("b2b2_rvalid", p1_rvalid, 1);
        chk("b2b2_rdata",  p1_rdata,  32'hA5A5_A5A5);

        // Out-of-range write at DEPTH: error, no memory write.
        @(negedge clk);
        drv1(1'b1, 1'b1, 32'd100, 32'hDEAD_BEEF);
        #1;
        chk("oorw_p1_gnt", p1_gnt, 1);
        chk("oorw_p1_err", p1_err, 1);
        chk("oorw_p0_err", p0_err, 0);
        chk("oorw_mem_we", mem_WE, 0);
        after_rise();
        chk("oorw_rvalid", p1_rvalid, 0);
        chk("oorw_hold",   p1_rdata,  32'hA5A5_A5A5);

        // Out-of-range read: error, rvalid still pulses, data zero.
        @(negedge clk);
        drv1(1'b1, 1'b0, 32'd200, 32'd0);
        #1;
        chk("oorr_p1_err", p1_err, 1);
        after_rise();
        chk("oorr_rvalid", p1_rvalid, 1);
        chk("oorr_rdata",  p1_rdata,  0);

        // Last valid address is writable.
        @(negedge clk);
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        drv0(1'b1, 1'b1, 32'd99, 32'h0000_0099);
        #1;
        chk("a99_p0_err", p0_err, 0);
        chk("a99_p1_err", p1_err, 0);
        chk("a99_mem_we", mem_WE, 1);
        after_rise();
        chk("a99_mem", mem[99], 32'h0000_0099);

        // Reset in the cycle of a p1 read grant: the read never completes.
        @(negedge clk);
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        drv1(1'b1, 1'b0, 32'd10, 32'd0);
        after_rise();
        chk("mr_pre_rdata", p1_rdata, 32'hCAFE_0001);
        @(negedge clk);
        #1;
        chk("mr_p1_gnt", p1_gnt, 1);
        rst = 1'b0;
        after_rise();
        chk("mr_p1_rvalid", p1_rvalid, 0);
        chk("mr_p1_rdata",  p1_rdata,  0);
        chk("mr_p1_gnt_rst", p1_gnt,   0);
        chk("mr_mem_we",    mem_WE,    0);
        @(negedge clk);
        rst = 1'b1;
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        after_rise();
        chk("mr_post_rvalid", p1_rvalid, 0);

`ifdef DMEM_ARB_CLEAR_EN
        // Preload addr 7, then a clear sweep with p0 waiting.
        @(negedge clk);
        drv0(1'b1, 1'b1, 32'd7, 32'h0000_1234);
        after_rise();
        chk("cl_pre_mem", mem[7], 32'h0000_1234);
        @(negedge clk);
        drv0(1'b1, 1'b0, 32'd7, 32'd0);
        clr_start = 1'b1;
        #1;
        chk("cs_p0_gnt",  p0_gnt,   0);
        chk("cs_mem_we",  mem_WE,   0);
        chk("cs_busy",    clr_busy, 0);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            clr_start = (i == 50);
            #1;
            chk("cl_busy",   clr_busy, 1);
            chk("cl_p0_gnt", p0_gnt,   0);
            chk("cl_mem_we", mem_WE,   1);
            chk("cl_mem_a",  mem_A,    32'(i));
            chk("cl_mem_wd", mem_WD,   0);
            @(negedge clk);
        end
        clr_start = 1'b0;
        #1;
        chk("cd_busy",   clr_busy, 0);
        chk("cd_p0_gnt", p0_gnt,   1);
        after_rise();
        chk("cd_rvalid", p0_rvalid, 1);
        chk("cd_rdata",  p0_rdata,  0);

        // Reset part-way through a sweep aborts it.
        @(negedge clk);
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        after_rise();
        chk("ab_busy", clr_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        drv0(1'b1, 1'b0, 32'd7, 32'd0);
        #1;
        chk("ab_p0_gnt", p0_gnt,   1);
        chk("ab_busy2",  clr_busy, 0);
`else
        // Without the clear feature, clr_start has no effect.
        @(negedge clk);
        drv0(1'b1, 1'b0, 32'd5, 32'd0);
        clr_start = 1'b1;
        #1;
        chk("nc_p0_gnt", p0_gnt,   1);
        chk("nc_busy",   clr_busy, 0);
        after_rise();
        chk("nc_rvalid", p0_rvalid, 1);
        chk("nc_rdata",  p0_rdata,  32'hA5A5_A5A5);
        chk("nc_busy2",  clr_busy,  0);
`endif

        @(negedge clk);
        drv0(1'b0, 1'b0, 32'd0, 32'd0);
        drv1(1'b0, 1'b0, 32'd0, 32'd0);
        clr_start = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
